sim_uart_line_arbiter: RTL
==========================

// Module: sim_uart_line_arbiter
// PURPOSE
//  Merges the per-core simulation UART byte streams (kernel, log, app) into one output stream.
//  Each channel is buffered in its own FIFO. Grant is line-atomic round-robin: a granted channel
//  keeps the output until it emits CR (0x0d) or LF (0x0a), so lines from different channels never interleave.
//  Sits between the cram_fpga sim_uart_* taps and a single line printer/logger in the testbench.
// PARAMETERS
//  NCH        3     number of input channels (0=kernel, 1=log, 2=app)
//  DEPTH      16    per-channel FIFO depth in bytes, power of 2, >=2
//  TIMEOUT    1024  idle cycles before a forced grant release (only with SIM_UART_TIMEOUT_EN)
// PORTS
//  clk        in   1              system clock
//  resetn     in   1              asynchronous active-low reset
//  in_data    in   NCH*8          channel i byte at [8*i+7:8*i]
//  in_valid   in   NCH            one-cycle byte strobe per channel; no backpressure to source
//  out_data   out  8              merged byte
//  out_valid  out  1              out_data valid
//  out_ready  in   1              sink accepts byte when out_valid&out_ready
//  out_chan   out  $clog2(NCH)    source channel of out_data
//  overflow   out  NCH            sticky: channel i dropped >=1 byte
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_chan=0, overflow=0, all FIFOs empty, state=IDLE, rr_ptr=0.
//  Reset mid-operation flushes all FIFOs and any partial line immediately (async).
//  FIFO write: in_valid[i] pushes in_data[i] when count_i<DEPTH, or when count_i==DEPTH and the same
//   cycle pops channel i. Otherwise the byte is dropped and overflow[i] is set (cleared only by reset).
//  FSM states:
//   IDLE: scan channels starting at rr_ptr and wrapping modulo NCH; the first non-empty channel is
//    latched as grant. Next state is GRANT. If all FIFOs are empty, stay in IDLE.
//   GRANT: out_valid = !empty(grant); out_data = head(grant); out_chan = grant.
//    Pop on out_valid&out_ready.
//    If the popped byte is 0x0d or 0x0a: next state is IDLE and rr_ptr = (grant+1) mod NCH.
//    If the granted FIFO is empty: hold grant with out_valid=0. Other channels keep buffering.
//  out_data and out_chan are stable while out_valid&!out_ready.
//  Latency: a byte written at cycle t to an empty FIFO while IDLE is first presented at t+2.
//   If its channel is already granted, it is presented at t+1.
//  Back-to-back: a CR followed by LF on the same channel costs one IDLE cycle between the two bytes.
//   The LF may be regranted to another channel first if rr order dictates.
//  Simultaneous in_valid on all channels is legal; every FIFO is written independently in the same cycle.
// CONFIGURATION
//  SIM_UART_TIMEOUT_EN defined:
//   In GRANT, a counter increments each cycle the granted FIFO is empty and resets on every pop.
//   When the counter reaches TIMEOUT and another FIFO is non-empty, go to IDLE with
//    rr_ptr = (grant+1) mod NCH. The partial line stays split; no bytes are lost.
//  SIM_UART_TIMEOUT_EN undefined:
//   No counter. The grant is held indefinitely until CR or LF; the TIMEOUT parameter is ignored.
// STRUCTURE
//  sim_uart_pkg holds: CHAN_KERNEL/CHAN_LOG/CHAN_APP indices, ASCII_CR=8'h0d, ASCII_LF=8'h0a,
//   typedef enum logic {IDLE, GRANT} arb_state_t, and function is_eol(byte).
//  Sub-module sim_uart_fifo #(DEPTH): byte FIFO with push/pop, full/empty, head, and count;
//   instantiated NCH times via generate.
//  Top level holds the FSM, the round-robin pointer, the output mux, the overflow flags,
//   and the optional timeout counter.
// TESTING
//  1 Single line: "HI\n" on ch0 with out_ready=1 -> out 'H','I',0x0a with out_chan=0; first byte 2 cycles after first strobe.
//  2 Interleave: "AB\n" on ch0 and "xy\n" on ch1 strobed in the same cycles -> output "AB\n" then "xy\n", never mixed.
//  3 Fairness: ch0,ch1,ch2 each hold 3 queued lines -> grant order 0,1,2,0,1,2,0,1,2.
//  4 Overflow: out_ready=0, push 17 bytes to ch1 (DEPTH=16) -> overflow=3'b010, first 16 bytes delivered in order after release.
//  5 Stall: toggle out_ready randomly during "hello\r" -> data/chan stable while stalled, exact 6-byte sequence out.
//  6 Reset: assert resetn low mid-line on ch2 -> out_valid=0 same cycle, FIFOs empty, overflow=0; new "Z\n" on ch0 is granted first.
//  (TIMEOUT_EN build) ch0 sends "ab" with no EOL, ch1 queues "c\n" -> after 1024 idle cycles "c\n" is output, then ch0 resumes.

Source files
------------

// File: rtl/sim_uart_line_arbiter_pkg.sv
// Shared constants, state type and helpers for the simulation UART line arbiter.
package sim_uart_line_arbiter_pkg;

  localparam int CHAN_KERNEL = 0;
  localparam int CHAN_LOG    = 1;
  localparam int CHAN_APP    = 2;

  localparam logic [7:0] ASCII_CR = 8'h0d;
  localparam logic [7:0] ASCII_LF = 8'h0a;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // A line ends on either carriage return or line feed.
  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/sim_uart_line_arbiter_if.sv
// Byte-stream bundle between the per-core UART taps, the arbiter and the line printer.
interface sim_uart_line_arbiter_if #(
  parameter int NCH = 3
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*8-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_chan;
  logic [NCH-1:0]   overflow;

  // Producer/consumer side: drives the byte taps and the sink ready.
  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, out_chan, overflow
  );

  // Arbiter side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, out_chan, overflow
  );
endinterface

// File: rtl/sim_uart_line_arbiter_fifo.sv
// Per-channel byte FIFO. A push into a full FIFO is accepted only when the
// same cycle pops, so the slot being read is the one rewritten.
module sim_uart_line_arbiter_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [7:0]               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Byte storage; cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Read/write pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
      r_rd_ptr <= w_rd ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
      r_count  <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/sim_uart_line_arbiter.sv
// Merges NCH simulation UART byte streams into one, granting whole lines
// round-robin so lines from different cores never interleave.
// Optional feature macro: SIM_UART_TIMEOUT_EN (forced grant release after
// TIMEOUT empty cycles while another channel is waiting).
module sim_uart_line_arbiter
  import sim_uart_line_arbiter_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  sim_uart_line_arbiter_if.slave  bus
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = $clog2(DEPTH);

  logic [NCH-1:0] w_empty;
  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_pop;
  logic [7:0]     w_head  [NCH];
  logic [AW:0]    w_count [NCH];

  arb_state_t     r_state, w_state_nxt;
  logic [CW-1:0]  r_grant, w_grant_nxt;
  logic [CW-1:0]  r_rr_ptr, w_rr_nxt;
  logic [CW-1:0]  w_grant_inc;
  logic [CW-1:0]  w_scan_idx;
  logic           w_scan_found;
  logic [CW:0]    w_dist;
  logic [CW:0]    w_best_dist;
  logic [7:0]     w_head_sel;
  logic           w_grant_empty;
  logic           w_out_valid;
  logic           w_fire;
  logic           w_eol_pop;
  logic           w_release;
  logic           w_unused_cnt;
  logic [NCH-1:0] r_overflow;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_fifo
    sim_uart_line_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (bus.in_valid[gi]),
      .i_data  (bus.in_data[8*gi +: 8]),
      .i_pop   (w_pop[gi]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi]),
      .o_head  (w_head[gi]),
      .o_count (w_count[gi])
    );
    assign w_pop[gi] = w_fire && (r_grant == CW'(gi));
  end

  // Head byte and emptiness of the currently granted channel.
  always_comb begin
    w_head_sel    = 8'h00;
    w_grant_empty = 1'b1;
    w_unused_cnt  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      w_unused_cnt  = w_unused_cnt ^ (^w_count[i]);
      w_head_sel    = (r_grant == CW'(i)) ? w_head[i]  : w_head_sel;
      w_grant_empty = (r_grant == CW'(i)) ? w_empty[i] : w_grant_empty;
    end
  end

  // Round-robin scan: nearest non-empty channel at or after rr_ptr (mod NCH).
  always_comb begin
    w_scan_found = 1'b0;
    w_scan_idx   = '0;
    w_best_dist  = (CW+1)'(NCH);
    w_dist       = '0;
    for (int i = 0; i < NCH; i++) begin
      w_dist = (CW'(i) >= r_rr_ptr) ? ((CW+1)'(i) - {1'b0, r_rr_ptr})
                                    : ((CW+1)'(i + NCH) - {1'b0, r_rr_ptr});
      w_scan_found = (!w_empty[i] && (w_dist < w_best_dist)) ? 1'b1   : w_scan_found;
      w_scan_idx   = (!w_empty[i] && (w_dist < w_best_dist)) ? CW'(i) : w_scan_idx;
      w_best_dist  = (!w_empty[i] && (w_dist < w_best_dist)) ? w_dist : w_best_dist;
    end
  end

  assign w_grant_inc = (r_grant == CW'(NCH-1)) ? '0 : (r_grant + CW'(1));
  assign w_out_valid = (r_state == GRANT) && !w_grant_empty;
  assign w_fire      = w_out_valid && bus.out_ready;
  assign w_eol_pop   = w_fire && is_eol(w_head_sel);

`ifdef SIM_UART_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]  r_tmo_cnt;
  logic [NCH-1:0] w_grant_oh;

  // One-hot of the granted channel, used to see whether anyone else waits.
  always_comb begin
    w_grant_oh = '0;
    for (int i = 0; i < NCH; i++) w_grant_oh[i] = (r_grant == CW'(i));
  end

  assign w_release = (r_state == GRANT) && (r_tmo_cnt == TW'(TIMEOUT)) &&
                     (|(~w_empty & ~w_grant_oh));

  // Counts starved cycles of the granted channel; any pop restarts it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tmo_cnt <= '0;
    end else if ((r_state != GRANT) || w_fire) begin
      r_tmo_cnt <= '0;
    end else if (w_grant_empty && (r_tmo_cnt != TW'(TIMEOUT))) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_release        = 1'b0;
`endif

  // Next-state logic: grant on any waiting channel, release on end of line.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_scan_found) begin
          w_state_nxt = GRANT;
          w_grant_nxt = w_scan_idx;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (w_eol_pop || w_release) begin
          w_state_nxt = IDLE;
          w_rr_nxt    = w_grant_inc;
        end else begin
          w_state_nxt = GRANT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, current grant and round-robin pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Sticky drop flags: a strobe the FIFO could not take.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow <= '0;
    end else begin
      r_overflow <= r_overflow | (bus.in_valid & w_full & ~w_pop);
    end
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_head_sel : 8'h00;
  assign bus.out_chan  = r_grant;
  assign bus.overflow  = r_overflow;
endmodule
